// File: rtl/slave_serial_rx.sv
// slave_serial_rx: bit-serial address/data receiver with burst sequencing for a bus slave.
// Optional data parity checking is enabled by defining SLAVE_RX_PARITY_EN.
`default_nettype none

module slave_serial_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int BURST_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_data,
    input  logic                   rx_addr,
    input  logic                   master_valid,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [BURST_WIDTH-1:0] burst,
    input  logic                   mem_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic                   wr_valid,
    output logic                   read_enable,
    output logic                   slave_ready,
    output logic                   rx_done,
    output logic                   rx_abort,
    output logic                   parity_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_WR_REQ = 3'd3,
        S_GAP    = 3'd4,
        S_RD_REQ = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam int CNT_W = $clog2(ADDR_WIDTH + DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);
`ifdef SLAVE_RX_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_BIT   = CNT_W'(DATA_WIDTH);
`endif

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [ADDR_WIDTH-2:0]   addr_sh;
    logic [DATA_WIDTH-2:0]   data_sh;
    logic [ADDR_WIDTH-1:0]   addr_cur;
    logic [BURST_WIDTH-1:0]  remaining;
    logic                    is_read;

    // Shift registers hold all but the final bit; the final bit is merged on the fly.
    logic                    start;
    logic [BURST_WIDTH-1:0]  burst_len;
    logic [ADDR_WIDTH-1:0]   addr_full;
    logic [DATA_WIDTH-1:0]   data_full;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic                    last_word;

    assign start     = master_valid & (write_en ^ read_en);
    assign burst_len = (burst == '0) ? BURST_WIDTH'(1) : burst;
    assign addr_full = {addr_sh, rx_addr};
    assign data_full = {data_sh, rx_data};
    assign addr_inc  = addr_cur + ADDR_WIDTH'(1);
    assign last_word = (remaining == BURST_WIDTH'(1));

`ifndef SLAVE_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            addr_cur    <= '0;
            remaining   <= '0;
            is_read     <= 1'b0;
            data_out    <= '0;
            addr_out    <= '0;
            wr_valid    <= 1'b0;
            read_enable <= 1'b0;
            slave_ready <= 1'b1;
            rx_done     <= 1'b0;
            rx_abort    <= 1'b0;
`ifdef SLAVE_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_done  <= 1'b0;
            rx_abort <= 1'b0;
            if (state != S_IDLE && state != S_DONE && !master_valid) begin
                state       <= S_IDLE;
                rx_abort    <= 1'b1;
                wr_valid    <= 1'b0;
                read_enable <= 1'b0;
                slave_ready <= 1'b1;
                bit_cnt     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            is_read     <= read_en;
                            remaining   <= burst_len;
                            bit_cnt     <= '0;
                            slave_ready <= 1'b0;
                            state       <= S_ADDR;
`ifdef SLAVE_RX_PARITY_EN
                            parity_err  <= 1'b0;
`endif
                        end
                    end
                    S_ADDR: begin
                        addr_sh <= (ADDR_WIDTH-1)'({addr_sh, rx_addr});
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt  <= '0;
                            addr_cur <= addr_full;
                            if (is_read) begin
                                addr_out    <= addr_full;
                                read_enable <= 1'b1;
                                state       <= S_RD_REQ;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        data_sh <= (DATA_WIDTH-1)'({data_sh, rx_data});
`ifdef SLAVE_RX_PARITY_EN
                        // Word lands in data_out one cycle early so the parity bit can be checked against it.
                        if (bit_cnt == WORD_LAST)
                            data_out <= data_full;
                        if (bit_cnt == PAR_BIT) begin
                            if (^{data_out, rx_data})
                                parity_err <= 1'b1;
                            bit_cnt  <= '0;
                            addr_out <= addr_cur;
                            wr_valid <= 1'b1;
                            state    <= S_WR_REQ;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
`else
                        if (bit_cnt == WORD_LAST) begin
                            data_out <= data_full;
                            bit_cnt  <= '0;
                            addr_out <= addr_cur;
                            wr_valid <= 1'b1;
                            state    <= S_WR_REQ;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
`endif
                    end
                    S_WR_REQ: begin
                        if (mem_ready) begin
                            wr_valid  <= 1'b0;
                            remaining <= remaining - BURST_WIDTH'(1);
                            if (last_word) begin
                                rx_done <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        addr_cur <= addr_inc;
                        state    <= S_DATA;
                    end
                    S_RD_REQ: begin
                        if (mem_ready) begin
                            remaining <= remaining - BURST_WIDTH'(1);
                            addr_cur  <= addr_inc;
                            addr_out  <= addr_inc;
                            if (last_word) begin
                                read_enable <= 1'b0;
                                rx_done     <= 1'b1;
                                state       <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        slave_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                    default: begin
                        slave_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slave_serial_rx.sv
// tb_slave_serial_rx: directed self-checking bench for slave_serial_rx.
`default_nettype none

module tb_slave_serial_rx;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int BW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_data;
    logic          rx_addr;
    logic          master_valid;
    logic          read_en;
    logic          write_en;
    logic [BW-1:0] burst;
    logic          mem_ready;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
    logic          wr_valid;
    logic          read_enable;
    logic          slave_ready;
    logic          rx_done;
    logic          rx_abort;
    logic          parity_err;

    int errors = 0;
    int checks = 0;

    slave_serial_rx #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_WIDTH(BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_addr     (rx_addr),
        .master_valid(master_valid),
        .read_en     (read_en),
        .write_en    (write_en),
        .burst       (burst),
        .mem_ready   (mem_ready),
        .data_out    (data_out),
        .addr_out    (addr_out),
        .wr_valid    (wr_valid),
        .read_enable (read_enable),
        .slave_ready (slave_ready),
        .rx_done     (rx_done),
        .rx_abort    (rx_abort),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_txn(input logic rd, input logic [BW-1:0] b);
        master_valid = 1'b1;
        read_en      = rd;
        write_en     = !rd;
        burst        = b;
        tick();
        read_en      = 1'b0;
        write_en     = 1'b0;
    endtask

    task automatic send_addr(input logic [AW-1:0] a);
        for (int i = AW - 1; i >= 0; i--) begin
            rx_addr = a[i];
            tick();
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--) begin
            rx_data = d[i];
            tick();
        end
`ifdef SLAVE_RX_PARITY_EN
        rx_data = ^d;
        tick();
`endif
    endtask

    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] abort_addr;

    initial begin
        reset = 1'b0; rx_data = 1'b0; rx_addr = 1'b0; master_valid = 1'b0;
        read_en = 1'b0; write_en = 1'b0; burst = '0; mem_ready = 1'b0;
        tick();
        check("rst_ready",  32'(slave_ready), 32'h1);
        check("rst_wv",     32'(wr_valid),    32'h0);
        check("rst_re",     32'(read_enable), 32'h0);
        check("rst_data",   32'(data_out),    32'h0);
        check("rst_addr",   32'(addr_out),    32'h0);
        check("rst_done",   32'(rx_done),     32'h0);
        check("rst_abort",  32'(rx_abort),    32'h0);
        check("rst_parity", 32'(parity_err),  32'h0);
        reset = 1'b1;
        tick();

        // Single write: wr_valid seen at T21, rx_done at T22, ready at T23
        mem_ready = 1'b1;
        start_txn(1'b0, BW'(1));
        check("sw_busy", 32'(slave_ready), 32'h0);
        send_addr(12'h0A5);
        send_word(8'h3C);
        check("sw_wv",   32'(wr_valid), 32'h1);
        check("sw_addr", 32'(addr_out), 32'h0A5);
        check("sw_data", 32'(data_out), 32'h3C);
        tick();
        check("sw_wv_drop", 32'(wr_valid),    32'h0);
        check("sw_done",    32'(rx_done),     32'h1);
        check("sw_notrdy",  32'(slave_ready), 32'h0);
        master_valid = 1'b0;
        tick();
        check("sw_done_pulse", 32'(rx_done),     32'h0);
        check("sw_ready",      32'(slave_ready), 32'h1);

        // Burst write across the address wrap, stall on word 2
        mem_ready = 1'b1;
        start_txn(1'b0, BW'(3));
        send_addr(12'hFFE);
        send_word(8'h11);
        check("bw1_wv",   32'(wr_valid), 32'h1);
        check("bw1_addr", 32'(addr_out), 32'hFFE);
        check("bw1_data", 32'(data_out), 32'h11);
        tick();
        check("bw1_gap", 32'(wr_valid), 32'h0);
        mem_ready = 1'b0;
        tick();
        send_word(8'h22);
        check("bw2_wv",   32'(wr_valid), 32'h1);
        check("bw2_addr", 32'(addr_out), 32'hFFF);
        check("bw2_data", 32'(data_out), 32'h22);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bw2_stall_wv",   32'(wr_valid), 32'h1);
            check("bw2_stall_addr", 32'(addr_out), 32'hFFF);
            check("bw2_stall_data", 32'(data_out), 32'h22);
        end
        mem_ready = 1'b1;
        tick();
        check("bw2_gap", 32'(wr_valid), 32'h0);
        check("bw2_nodone", 32'(rx_done), 32'h0);
        tick();
        send_word(8'h33);
        check("bw3_wv",   32'(wr_valid), 32'h1);
        check("bw3_addr", 32'(addr_out), 32'h000);
        check("bw3_data", 32'(data_out), 32'h33);
        tick();
        check("bw_done", 32'(rx_done), 32'h1);
        master_valid = 1'b0;
        tick();

        // Burst read with mem_ready 1,0,1,1,1
        start_txn(1'b1, BW'(4));
        send_addr(12'h100);
        exp_addr = 12'h100;
        for (int k = 0; k < 5; k++) begin
            mem_ready = pat[k];
            check("br_re",   32'(read_enable), 32'h1);
            check("br_addr", 32'(addr_out),    32'(exp_addr));
            check("br_nodone", 32'(rx_done),   32'h0);
            tick();
            if (pat[k]) exp_addr = exp_addr + 12'h1;
        end
        check("br_re_drop", 32'(read_enable), 32'h0);
        check("br_done",    32'(rx_done),     32'h1);
        master_valid = 1'b0;
        tick();
        check("br_done_pulse", 32'(rx_done),     32'h0);
        check("br_ready",      32'(slave_ready), 32'h1);

        // Burst length 0 behaves as a single word
        mem_ready = 1'b1;
        start_txn(1'b1, BW'(0));
        send_addr(12'h7FF);
        check("b0_re",   32'(read_enable), 32'h1);
        check("b0_addr", 32'(addr_out),    32'h7FF);
        tick();
        check("b0_re_drop", 32'(read_enable), 32'h0);
        check("b0_done",    32'(rx_done),     32'h1);
        master_valid = 1'b0;
        tick();

        // Abort after 5 address bits, then an illegal start
        abort_addr = 12'hABC;
        start_txn(1'b0, BW'(1));
        for (int i = AW - 1; i >= AW - 5; i--) begin
            rx_addr = abort_addr[i];
            tick();
        end
        master_valid = 1'b0;
        tick();
        check("ab_pulse", 32'(rx_abort),    32'h1);
        check("ab_ready", 32'(slave_ready), 32'h1);
        check("ab_wv",    32'(wr_valid),    32'h0);
        check("ab_done",  32'(rx_done),     32'h0);
        tick();
        check("ab_pulse_end", 32'(rx_abort), 32'h0);
        master_valid = 1'b1;
        read_en = 1'b1;
        write_en = 1'b1;
        repeat (3) tick();
        check("ill_ready", 32'(slave_ready), 32'h1);
        check("ill_re",    32'(read_enable), 32'h0);
        master_valid = 1'b0;
        read_en = 1'b0;
        write_en = 1'b0;
        tick();

`ifdef SLAVE_RX_PARITY_EN
        // 0x07 has odd weight, so a parity bit of 0 is wrong
        mem_ready = 1'b1;
        start_txn(1'b0, BW'(1));
        send_addr(12'h020);
        for (int i = DW - 1; i >= 0; i--) begin
            rx_data = (i < 3);
            tick();
        end
        rx_data = 1'b0;
        tick();
        check("par_wv",   32'(wr_valid),   32'h1);
        check("par_data", 32'(data_out),   32'h07);
        check("par_err",  32'(parity_err), 32'h1);
        tick();
        check("par_done", 32'(rx_done), 32'h1);
        master_valid = 1'b0;
        tick();
        check("par_sticky", 32'(parity_err), 32'h1);
        start_txn(1'b0, BW'(1));
        check("par_clear", 32'(parity_err), 32'h0);
        master_valid = 1'b0;
        tick();
        tick();
`else
        check("par_tied", 32'(parity_err), 32'h0);
`endif

        // Asynchronous reset during word 2 of a burst
        mem_ready = 1'b1;
        start_txn(1'b0, BW'(2));
        send_addr(12'h055);
        send_word(8'hA1);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            rx_data = 1'b1;
            tick();
        end
        #2 reset = 1'b0;
        #1;
        check("ar_ready", 32'(slave_ready), 32'h1);
        check("ar_wv",    32'(wr_valid),    32'h0);
        check("ar_addr",  32'(addr_out),    32'h0);
        check("ar_data",  32'(data_out),    32'h0);
        master_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("ar_nodone", 32'(rx_done),     32'h0);
        check("ar_idle",   32'(slave_ready), 32'h1);
        tick();
        check("ar_nodone2", 32'(rx_done), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slave_serial_rx.md
Name: slave_serial_rx

Overview:
Parametrised bit-serial receive port for a system-bus slave. It deserialises an address from `rx_addr` and write data from `rx_data`, each MSB first. It supports multi-word bursts with auto-incrementing address and presents parallel write or read requests to the slave memory with a ready/valid stall. It replaces the fixed 8-bit/12-bit single-word receiver and adds burst sequencing, back-pressure and abort handling.

Parameters:
- DATA_WIDTH, 8, bits per serial data word.
- ADDR_WIDTH, 12, bits per serial address.
- BURST_WIDTH, 13, width of the burst word-count input.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- rx_data, input, 1, serial write data, MSB first.
- rx_addr, input, 1, serial address, MSB first.
- master_valid, input, 1, master holds high for the whole transaction.
- read_en, input, 1, read transaction request.
- write_en, input, 1, write transaction request.
- burst, input, BURST_WIDTH, number of words in the transaction; 0 is treated as 1.
- mem_ready, input, 1, slave memory accepts the current request.
- data_out, output, DATA_WIDTH, assembled write word.
- addr_out, output, ADDR_WIDTH, address of the current word.
- wr_valid, output, 1, write request valid.
- read_enable, output, 1, read request valid.
- slave_ready, output, 1, idle and able to accept a new transaction.
- rx_done, output, 1, one-cycle pulse when a transaction completes.
- rx_abort, output, 1, one-cycle pulse when a transaction is aborted.
- parity_err, output, 1, sticky data parity error (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - slave_ready=1; all other outputs 0, including data_out, addr_out and parity_err.
  - Internal shift registers and counters are cleared.
- All outputs are registered.
- States: IDLE, ADDR, DATA, WR_REQ, GAP, RD_REQ, DONE.
- IDLE:
  - slave_ready=1.
  - Start condition: master_valid=1 with exactly one of write_en/read_en set.
    - Latch the operation and remaining=max(burst,1).
    - Clear the bit counter, drop slave_ready, go to ADDR.
  - write_en=read_en=1, or neither set: request ignored, stay in IDLE.
- ADDR:
  - Sample rx_addr on each of the next ADDR_WIDTH cycles.
  - Shift left into the address register (first sampled bit becomes the MSB).
  - After the last bit: write goes to DATA, read goes to RD_REQ.
- DATA:
  - Sample rx_data for DATA_WIDTH cycles, MSB first.
  - After the last bit, load data_out and addr_out, set wr_valid=1, go to WR_REQ.
- WR_REQ:
  - Hold wr_valid, data_out and addr_out stable while mem_ready=0.
  - On the cycle mem_ready=1, the word is accepted and remaining is decremented.
    - remaining becomes 0: go to DONE.
    - Otherwise: go to GAP.
  - wr_valid drops on the following cycle.
- GAP:
  - Exactly one idle cycle; the serial lines are not sampled.
  - Address increments by 1, modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000).
  - Return to DATA.
- RD_REQ:
  - read_enable=1 with addr_out=current address.
  - Each cycle with mem_ready=1 accepts one word: address increments (wrapping) and remaining is decremented.
  - read_enable stays high back-to-back across burst words with no gap.
  - When the last word is accepted, go to DONE.
- DONE: rx_done=1 for one cycle, then IDLE with slave_ready=1 on the next cycle.
- Abort:
  - If master_valid=0 in any state other than IDLE/DONE, go to IDLE on the next edge.
  - rx_abort pulses for one cycle; wr_valid and read_enable are cleared.
  - rx_done is not asserted; the partially shifted word is discarded.
- A write word already accepted (mem_ready=1 in the same cycle that master_valid falls) counts as delivered.
- Write latency, single word, with the start sampled at cycle T0:
  - Address bits are sampled at T1..T(ADDR_WIDTH).
  - Data bits are sampled at the next DATA_WIDTH cycles.
  - wr_valid is visible in the following cycle.
  - With defaults, wr_valid=1 at T21.
- Maximum burst is 2^BURST_WIDTH-1 words; no overflow of remaining is possible.

Optional Feature:
- Macro: SLAVE_RX_PARITY_EN.
- Defined:
  - In DATA, one extra bit is sampled on rx_data after each word: the even-parity bit over the word.
  - On mismatch, parity_err is set (sticky until the next start condition or reset).
  - The word is still delivered.
  - Burst timing becomes DATA_WIDTH+1 cycles per word.
- Not defined: no parity bit is sampled; parity_err is tied to 0.

Test Plan:
- Reset mid-burst (assert reset during the DATA state of word 2) -> outputs return to reset values immediately; slave_ready=1 asynchronously; no rx_done.
- Single write: addr=0x0A5, data=0x3C, burst=1, mem_ready=1 -> wr_valid=1 at T21 with addr_out=0x0A5 and data_out=0x3C; rx_done=1 at T22; slave_ready=1 at T23.
- Burst write: addr=0xFFE, burst=3, data 0x11/0x22/0x33, mem_ready held low 4 cycles on word 2 -> writes to 0xFFE, 0xFFF, 0x000; word 2 stays stable during the stall; one GAP cycle between words.
- Burst read: addr=0x100, burst=4, mem_ready toggling 1,0,1,1,1 -> read_enable for addresses 0x100..0x103, advancing only on mem_ready=1; a single rx_done pulse.
- Abort and illegal start: master_valid dropped after 5 address bits -> rx_abort pulse, back to IDLE, no wr_valid; then read_en=write_en=1 -> stays IDLE with slave_ready=1.
- With SLAVE_RX_PARITY_EN: word 0x07 sent with parity bit 0 -> word delivered and parity_err=1; next start clears parity_err.
